// File: rtl/mem_port_arbiter.sv
// Two-port to one-port memory arbiter with bounded-hold fairness.
// Each port keeps its last read word stable until that port's next read returns.

module mem_port_arbiter_rdret (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        rd_acc,
    input  logic [31:0] m_do,
    output logic [31:0] s_do
);
    logic        rd_ret;
    logic [31:0] do_latch;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ret   <= 1'b0;
            do_latch <= '0;
        end else begin
            rd_ret <= rd_acc;
            if (rd_ret)
                do_latch <= m_do;
        end
    end

    // Forward the returning word in its own cycle, then hold it from the latch.
    assign s_do = rd_ret ? m_do : do_latch;
endmodule

module mem_port_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s0_cs,
    input  logic        s0_we,
    input  logic [31:0] s0_addr,
    input  logic [3:0]  s0_byte,
    input  logic [31:0] s0_di,
    output logic [31:0] s0_do,
    output logic        s0_busy,
    input  logic        s1_cs,
    input  logic        s1_we,
    input  logic [31:0] s1_addr,
    input  logic [3:0]  s1_byte,
    input  logic [31:0] s1_di,
    output logic [31:0] s1_do,
    output logic        s1_busy,
    output logic        m_cs,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_byte,
    output logic [31:0] m_di,
    input  logic [31:0] m_do,
    input  logic        m_busy
);
    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    logic [1:0]       cs, we, gnt, acc, rd_acc;
    logic [1:0][31:0] addr, di, s_do;
    logic [1:0][3:0]  byte_en;
    logic             owner;
    logic [3:0]       hold_cnt;
    logic             keep_owner;
    logic             sel;

    assign cs      = {s1_cs, s0_cs};
    assign we      = {s1_we, s0_we};
    assign addr    = {s1_addr, s0_addr};
    assign byte_en = {s1_byte, s0_byte};
    assign di      = {s1_di, s0_di};

    // hold_cnt==0 only before the first acceptance: the reset owner (port 1)
    // then yields the first tie so port 0 wins it.
    assign keep_owner = (hold_cnt != 4'd0) && (hold_cnt < HOLD_LIM);

    always_comb begin
        gnt = 2'b00;
        case (cs)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (keep_owner) gnt = owner ? 2'b10 : 2'b01;
                else            gnt = owner ? 2'b01 : 2'b10;
            end
            default: gnt = 2'b00;
        endcase
    end

    assign sel    = gnt[1];
    assign acc    = gnt & {2{~m_busy}};
    assign rd_acc = acc & ~we;

    assign m_cs   = |cs;
    assign m_we   = we[sel];
    assign m_addr = addr[sel];
    assign m_byte = byte_en[sel];
    assign m_di   = di[sel];

    assign s0_busy = cs[0] & (m_busy | ~gnt[0]);
    assign s1_busy = cs[1] & (m_busy | ~gnt[1]);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            owner    <= 1'b1;
            hold_cnt <= 4'd0;
        end else if (|acc) begin
            if (acc[owner]) begin
                if (hold_cnt != 4'hF)
                    hold_cnt <= hold_cnt + 4'd1;
            end else begin
                owner    <= acc[1];
                hold_cnt <= 4'd1;
            end
        end
    end

    for (genvar n = 0; n < 2; n++) begin : g_port
        mem_port_arbiter_rdret u_rdret (
            .aclk    (aclk),
            .aresetn (aresetn),
            .rd_acc  (rd_acc[n]),
            .m_do    (m_do),
            .s_do    (s_do[n])
        );
    end

    assign s0_do = s_do[0];
    assign s1_do = s_do[1];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter; a behavioural model
// predicts every cycle's outputs into a queue checked by a separate monitor.

module tb_mem_port_arbiter;
    localparam int HM = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [1:0]  p_cs, p_we;
    logic [31:0] p_addr [2];
    logic [3:0]  p_byte [2];
    logic [31:0] p_di   [2];
    logic [31:0] s0_do, s1_do, m_addr, m_di, m_do;
    logic        s0_busy, s1_busy, m_cs, m_we, m_busy;
    logic [3:0]  m_byte;

    always #5 aclk = ~aclk;

    mem_port_arbiter #(.HOLD_MAX(HM)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_cs(p_cs[0]), .s0_we(p_we[0]), .s0_addr(p_addr[0]), .s0_byte(p_byte[0]),
        .s0_di(p_di[0]), .s0_do(s0_do), .s0_busy(s0_busy),
        .s1_cs(p_cs[1]), .s1_we(p_we[1]), .s1_addr(p_addr[1]), .s1_byte(p_byte[1]),
        .s1_di(p_di[1]), .s1_do(s1_do), .s1_busy(s1_busy),
        .m_cs(m_cs), .m_we(m_we), .m_addr(m_addr), .m_byte(m_byte), .m_di(m_di),
        .m_do(m_do), .m_busy(m_busy)
    );

    typedef struct {
        logic        m_cs, m_we;
        logic [31:0] m_addr, m_di, do0, do1;
        logic [3:0]  m_byte;
        logic [1:0]  busy;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Model: last accepted port (-1 = none yet) and its run length;
    // a read accepted last cycle returns this cycle's m_do to that port.
    int          lastp = -1;
    int          run = 0;
    bit          ret [2];
    logic [31:0] dexp [2];
    int          acc_port = -1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, ex, $time);
        end
    endtask

    task automatic eval_push();
        exp_t e;
        int   g, fp;
        if (!aresetn) begin
            lastp = -1; run = 0;
            ret[0] = 0; ret[1] = 0;
            dexp[0] = '0; dexp[1] = '0;
        end
        g = -1;
        if (p_cs[0] && p_cs[1])
            g = (lastp >= 0 && run < HM) ? lastp : ((lastp == 0) ? 1 : 0);
        else if (p_cs[0]) g = 0;
        else if (p_cs[1]) g = 1;
        for (int n = 0; n < 2; n++)
            if (ret[n]) dexp[n] = m_do;
        fp = (g == 1) ? 1 : 0;
        e.m_cs   = p_cs[0] | p_cs[1];
        e.m_we   = p_we[fp];
        e.m_addr = p_addr[fp];
        e.m_byte = p_byte[fp];
        e.m_di   = p_di[fp];
        for (int n = 0; n < 2; n++)
            e.busy[n] = p_cs[n] && (m_busy || g != n);
        e.do0 = dexp[0];
        e.do1 = dexp[1];
        acc_port = (aresetn && g >= 0 && !m_busy) ? g : -1;
        exp_q.push_back(e);
    endtask

    task automatic update();
        if (!aresetn) return;
        ret[0] = 0; ret[1] = 0;
        if (acc_port >= 0) begin
            if (!p_we[acc_port]) ret[acc_port] = 1;
            if (acc_port == lastp) run = (run < 15) ? run + 1 : 15;
            else begin lastp = acc_port; run = 1; end
        end
    endtask

    task automatic cyc_a();
        eval_push();
        @(negedge aclk);
    endtask

    task automatic cyc_b();
        @(posedge aclk);
        update();
        #1;
    endtask

    task automatic setp(int n, logic cs, logic we, logic [31:0] a, logic [3:0] b, logic [31:0] d);
        p_cs[n] = cs; p_we[n] = we; p_addr[n] = a; p_byte[n] = b; p_di[n] = d;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge aclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("m_cs",   32'(m_cs),   32'(e.m_cs));
                chk("m_we",   32'(m_we),   32'(e.m_we));
                chk("m_addr", m_addr,      e.m_addr);
                chk("m_byte", 32'(m_byte), 32'(e.m_byte));
                chk("m_di",   m_di,        e.m_di);
                chk("s_busy", 32'({s1_busy, s0_busy}), 32'(e.busy));
                chk("s0_do",  s0_do,       e.do0);
                chk("s1_do",  s1_do,       e.do1);
            end
        end
    end

    initial begin : stim
        aresetn = 1'b0; m_busy = 1'b0; m_do = 32'h1234_5678;
        setp(0, 1'b0, 1'b0, '0, '0, '0);
        setp(1, 1'b0, 1'b0, '0, '0, '0);
        #1;
        // reset state; m_cs follows requests while in reset
        cyc_a(); chk("rst_s0_do", s0_do, 32'h0); cyc_b();
        setp(1, 1'b1, 1'b0, 32'h44, 4'hF, 32'h0);
        cyc_a(); chk("rst_m_cs", 32'(m_cs), 32'h1); cyc_b();
        setp(1, 1'b0, 1'b0, '0, '0, '0);

        // first tie after reset goes to port 0, then runs of HM per port
        aresetn = 1'b1;
        setp(0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        setp(1, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
        for (int i = 0; i < 12; i++) begin
            m_do = $urandom;
            cyc_a();
            chk("pattern_addr", m_addr, ((i / HM) % 2 == 1) ? 32'h200 : 32'h100);
            if (i == 0) chk("first_s1_busy", 32'(s1_busy), 32'h1);
            cyc_b();
        end

        // memory stall freezes arbitration
        m_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_do = $urandom;
            cyc_a(); chk("stall_busy", 32'({s1_busy, s0_busy}), 32'h3); cyc_b();
        end
        m_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            m_do = $urandom; cyc_a(); cyc_b();
        end

        // port 0 read then port 1 writes: s0_do must stay put
        setp(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        setp(1, 1'b0, 1'b0, '0, '0, '0);
        cyc_a(); cyc_b();
        setp(0, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            setp(1, 1'b1, 1'b1, 32'h300 + 32'(i), 4'h3, $urandom);
            m_do = (i == 0) ? 32'hA5A5_A5A5 : $urandom;
            cyc_a(); chk("hold_s0_do", s0_do, 32'hA5A5_A5A5); cyc_b();
        end

        // back-to-back reads of alternating ports
        setp(1, 1'b0, 1'b0, '0, '0, '0);
        setp(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        cyc_a(); cyc_b();
        setp(0, 1'b0, 1'b0, '0, '0, '0);
        setp(1, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
        m_do = 32'h11;
        cyc_a(); cyc_b();
        setp(1, 1'b0, 1'b0, '0, '0, '0);
        m_do = 32'h22;
        cyc_a(); chk("alt_s0_do", s0_do, 32'h11); chk("alt_s1_do", s1_do, 32'h22); cyc_b();
        m_do = 32'h33;
        cyc_a(); chk("alt_s1_hold", s1_do, 32'h22); cyc_b();

        // reset right after a port 1 read accept discards the return
        setp(1, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
        cyc_a(); cyc_b();
        setp(1, 1'b0, 1'b0, '0, '0, '0);
        aresetn = 1'b0; m_do = 32'hDEAD_0001;
        cyc_a(); chk("rstmid_s1_do", s1_do, 32'h0); cyc_b();
        aresetn = 1'b1; m_do = 32'hDEAD_0002;
        cyc_a(); chk("post_rst_s1_do", s1_do, 32'h0); cyc_b();
        setp(0, 1'b1, 1'b1, 32'h500, 4'h1, 32'h5);
        setp(1, 1'b1, 1'b1, 32'h600, 4'h2, 32'h6);
        cyc_a(); chk("post_rst_tie", m_addr, 32'h500); cyc_b();

        // randomized traffic with stalls and occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (p_cs[n] && acc_port == n) p_cs[n] = 1'b0;
                if (!p_cs[n] && $urandom_range(0, 99) < 65)
                    setp(n, 1'b1, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom);
            end
            m_busy  = ($urandom_range(0, 99) < 20);
            m_do    = $urandom;
            aresetn = ($urandom_range(0, 299) != 0);
            cyc_a(); cyc_b();
        end

        @(negedge aclk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
